// File: rtl/ifmap_glb_reader.sv
// Streaming reader for ifmap GLB port B: issues one read per cycle, absorbs the one-cycle read latency,
// and delivers the elements in order on a valid/ready stream. Define IFMAP_RD_WRAP_EN for circular addressing.
module ifmap_glb_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 154588,
  parameter int ADDR       = $clog2(DEPTH),
  parameter int LEN_W      = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR-1:0]       base_addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic                  re_b,
  output logic [ADDR-1:0]       addr_b,
  input  logic [DATA_WIDTH-1:0] rdata_b,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [ADDR-1:0]       addr_r;
  logic [LEN_W-1:0]      remaining_r;
  logic                  inflight_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [3];
  logic [1:0]            wr_ptr_r;
  logic [1:0]            rd_ptr_r;
  logic [1:0]            fifo_count_r;

  logic issue_s;
  logic push_s;
  logic pop_s;
  logic accept_s;
  logic zero_cmd_s;
  logic last_pop_s;
  logic credit_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [ADDR-1:0] addr_inc(input logic [ADDR-1:0] a);
`ifdef IFMAP_RD_WRAP_EN
    return (a == ADDR'(DEPTH - 1)) ? {ADDR{1'b0}} : a + ADDR'(1);
`else
    return a + ADDR'(1);
`endif
  endfunction

  // Slots held by buffered data plus the read still in flight bound how many reads may be outstanding.
  assign credit_s   = ({1'b0, fifo_count_r} + {2'b00, inflight_r}) < 3'd3;
  assign issue_s    = (state_r == RUN) && (remaining_r != {LEN_W{1'b0}}) && credit_s;
  assign push_s     = inflight_r;
  assign pop_s      = (fifo_count_r != 2'd0) && out_ready;
  assign accept_s   = (state_r == IDLE) && start && (len != {LEN_W{1'b0}});
  assign zero_cmd_s = (state_r == IDLE) && start && (len == {LEN_W{1'b0}});
  assign last_pop_s = pop_s && (fifo_count_r == 2'd1) && !inflight_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (issue_s && (remaining_r == LEN_W'(1))) state_s = DRAIN;
        else                                       state_s = RUN;
      end
      DRAIN: begin
        if (last_pop_s) state_s = IDLE;
        else            state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy      = (state_r != IDLE);
    done      = done_r;
    re_b      = issue_s;
    addr_b    = addr_r;
    out_valid = (fifo_count_r != 2'd0);
    if (fifo_count_r != 2'd0) out_data = fifo_mem_r[rd_ptr_r];
    else                      out_data = {DATA_WIDTH{1'b0}};
  end

  // Address/remaining counters, read-latency tracker and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= {ADDR{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      inflight_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      done_r     <= zero_cmd_s || ((state_r == DRAIN) && last_pop_s);
      if (accept_s) begin
        addr_r      <= base_addr;
        remaining_r <= len;
      end else if (issue_s) begin
        addr_r      <= addr_inc(addr_r);
        remaining_r <= remaining_r - LEN_W'(1);
      end else begin
        addr_r      <= addr_r;
        remaining_r <= remaining_r;
      end
    end
  end

  // Three-entry output FIFO; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
      wr_ptr_r     <= 2'd0;
      rd_ptr_r     <= 2'd0;
      fifo_count_r <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= rdata_b;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + 2'd1;
        2'b01:   fifo_count_r <= fifo_count_r - 2'd1;
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

endmodule
